// File: rtl/neighborhood_pkg.sv
// Shared types and helpers for the neighborhood window generator:
// FSM state encoding, window geometry and coordinate widths.
package neighborhood_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Window radius for an odd edge length.
    function automatic int calc_r(input int n_size);
        return (n_size - 1) / 2;
    endfunction

    // Stream distance between a center pixel and the newest pixel of its window.
    function automatic int calc_l(input int n_size, input int img_width);
        return calc_r(n_size) * img_width + calc_r(n_size);
    endfunction

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_X_W = coord_w(640);
    localparam int DEF_Y_W = coord_w(480);

    // True when coordinate c+off lies inside [0, lim).
    function automatic logic tap_inside(input int c, input int off, input int lim);
        int p;
        p = c + off;
        return (p >= 0) && (p < lim);
    endfunction

endpackage

// File: rtl/neighborhood_window_if.sv
// Pixel-in / window-out bundle of the neighborhood window generator.
interface neighborhood_window_if
    import neighborhood_pkg::*;
#(
    parameter int COLORS     = 1,
    parameter int N_SIZE     = 5,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    localparam int X_W = coord_w(IMG_WIDTH);
    localparam int Y_W = coord_w(IMG_HEIGHT);

    logic                                        in_valid;
    logic                                        in_ready;
    logic                                        in_sof;
    logic [COLORS-1:0]                           in_pixel;
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0]   out_img;
    logic                                        out_valid;
    logic                                        out_sof;
    logic                                        out_last;
    logic [X_W-1:0]                              out_x;
    logic [Y_W-1:0]                              out_y;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  in_ready, out_img, out_valid, out_sof, out_last, out_x, out_y
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output in_ready, out_img, out_valid, out_sof, out_last, out_x, out_y
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of delay: combinational read of the old word, write of the
// new word at the same address on the clock edge (read-before-write).
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 1,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[addr];

    // Line storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/neighborhood_window.sv
// Raster stream to N_SIZE x N_SIZE window generator with self-flush at frame end.
// Optional out-of-frame tap zeroing: define NEIGHBORHOOD_BORDER_MASK_EN.
module neighborhood_window
    import neighborhood_pkg::*;
#(
    parameter int N_SIZE     = 5,
    parameter int COLORS     = 1,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 reset_n,
    neighborhood_window_if.slave bus
);

    localparam int R   = calc_r(N_SIZE);
    localparam int L   = calc_l(N_SIZE, IMG_WIDTH);
    localparam int X_W = coord_w(IMG_WIDTH);
    localparam int Y_W = coord_w(IMG_HEIGHT);
    localparam int F_W = coord_w(L + 1);

    typedef logic [COLORS-1:0]                         pix_t;
    typedef logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] win_t;

    localparam logic [X_W-1:0] X_MAX    = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(IMG_HEIGHT - 1);
    localparam logic [F_W-1:0] F_FULL   = F_W'(L);
    localparam logic [F_W-1:0] F_LAST   = F_W'(L - 1);
    localparam win_t           WIN_ZERO = {(N_SIZE*N_SIZE*COLORS){1'b0}};

    state_t         state_r;
    logic           in_ready_r;
    logic [X_W-1:0] in_x_r;
    logic [Y_W-1:0] in_y_r;
    logic [F_W-1:0] fill_r;
    logic [F_W-1:0] flush_cnt_r;
    logic [X_W-1:0] cx_r;
    logic [Y_W-1:0] cy_r;
    win_t           win_r;

    logic           out_valid_r;
    logic           out_sof_r;
    logic           out_last_r;
    logic [X_W-1:0] out_x_r;
    logic [Y_W-1:0] out_y_r;
    win_t           out_img_r;

    logic           beat_s;
    logic           start_s;
    logic           shift_s;
    logic           emit_s;
    logic           last_s;
    logic [X_W-1:0] cur_x_s;
    logic [X_W-1:0] nxt_x_s;
    logic [Y_W-1:0] cur_y_s;
    logic [Y_W-1:0] nxt_y_s;
    pix_t           pix_s;
    pix_t           col_s [N_SIZE];
    win_t           win_next_s;
    win_t           masked_s;

    assign beat_s  = bus.in_valid & in_ready_r;
    assign start_s = beat_s & bus.in_sof & (state_r != FLUSH);
    assign shift_s = (state_r == FLUSH) | ((state_r == RUN) & beat_s) | start_s;
    assign pix_s   = (state_r == FLUSH) ? {COLORS{1'b0}} : bus.in_pixel;

    // A start-of-frame beat always lands at (0,0), whatever the counters held.
    assign cur_x_s = start_s ? {X_W{1'b0}} : in_x_r;
    assign cur_y_s = start_s ? {Y_W{1'b0}} : in_y_r;
    assign nxt_x_s = (cur_x_s == X_MAX) ? {X_W{1'b0}} : cur_x_s + X_W'(1);
    assign nxt_y_s = (cur_x_s == X_MAX) ? cur_y_s + Y_W'(1) : cur_y_s;
    assign last_s  = (state_r != FLUSH) & (cur_x_s == X_MAX) & (cur_y_s == Y_MAX);
    assign emit_s  = shift_s & ~start_s & (fill_r == F_FULL);

    // Bottom window row takes the new pixel; each line buffer feeds the row above.
    assign col_s[N_SIZE-1] = pix_s;
    for (genvar m = 0; m < N_SIZE - 1; m++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (COLORS),
            .AW    (X_W)
        ) u_lb (
            .clk     (clk),
            .we      (shift_s),
            .addr    (cur_x_s),
            .wr_data (col_s[N_SIZE-1-m]),
            .rd_data (col_s[N_SIZE-2-m])
        );
    end

    // Window contents after shifting one column in from the right.
    always_comb begin
        win_next_s = win_r;
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE - 1; j++) begin
                win_next_s[i][j] = win_r[i][j+1];
            end
            win_next_s[i][N_SIZE-1] = col_s[i];
        end
    end

    // Optional zeroing of taps that fall outside the frame around the center.
    always_comb begin
        masked_s = win_next_s;
`ifdef NEIGHBORHOOD_BORDER_MASK_EN
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE; j++) begin
                if (tap_inside(int'(cx_r), j - R, IMG_WIDTH) &&
                    tap_inside(int'(cy_r), i - R, IMG_HEIGHT)) begin
                    masked_s[i][j] = win_next_s[i][j];
                end else begin
                    masked_s[i][j] = {COLORS{1'b0}};
                end
            end
        end
`endif
    end

    // Frame FSM, stream counters, window shift and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            in_x_r      <= {X_W{1'b0}};
            in_y_r      <= {Y_W{1'b0}};
            fill_r      <= {F_W{1'b0}};
            flush_cnt_r <= {F_W{1'b0}};
            cx_r        <= {X_W{1'b0}};
            cy_r        <= {Y_W{1'b0}};
            win_r       <= WIN_ZERO;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_last_r  <= 1'b0;
            out_x_r     <= {X_W{1'b0}};
            out_y_r     <= {Y_W{1'b0}};
            out_img_r   <= WIN_ZERO;
        end else begin
            out_valid_r <= emit_s;
            out_sof_r   <= emit_s & (cx_r == {X_W{1'b0}}) & (cy_r == {Y_W{1'b0}});
            out_last_r  <= emit_s & (cx_r == X_MAX) & (cy_r == Y_MAX);
            if (emit_s) begin
                out_img_r <= masked_s;
                out_x_r   <= cx_r;
                out_y_r   <= cy_r;
            end

            if (shift_s) begin
                win_r  <= win_next_s;
                in_x_r <= nxt_x_s;
                in_y_r <= nxt_y_s;
            end

            // A new frame drops every pending center of the old one.
            if (start_s) begin
                fill_r <= F_W'(1);
                cx_r   <= {X_W{1'b0}};
                cy_r   <= {Y_W{1'b0}};
            end else begin
                if (shift_s && (fill_r != F_FULL)) begin
                    fill_r <= fill_r + F_W'(1);
                end
                if (emit_s) begin
                    cx_r <= (cx_r == X_MAX) ? {X_W{1'b0}} : cx_r + X_W'(1);
                    cy_r <= (cx_r == X_MAX) ? cy_r + Y_W'(1) : cy_r;
                end
            end

            case (state_r)
                IDLE, RUN: begin
                    if (shift_s && last_s) begin
                        state_r     <= FLUSH;
                        in_ready_r  <= 1'b0;
                        flush_cnt_r <= {F_W{1'b0}};
                    end else if (start_s) begin
                        state_r    <= RUN;
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r == F_LAST) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + F_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sof   = out_sof_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_img   = out_img_r;

endmodule

// File: doc/neighborhood_window.md
# neighborhood_window

Streaming window generator that turns a raster pixel stream into the N_SIZE×N_SIZE neighborhood consumed by the majority filter in the AR-pong vision pipeline. It buffers N_SIZE-1 image lines, shifts in one pixel per accepted beat and presents the full window around a center pixel. It also reports that pixel's coordinates and frame markers. At end of frame it flushes the trailing rows itself so every input pixel gets exactly one output window.

## Interface
Parameters:
- N_SIZE, 5, window edge (odd, ≥3); R = (N_SIZE-1)/2
- COLORS, 1, bits per pixel (one bit per color mask)
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame

Ports:
- clk  in  1  system clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  input pixel present
- in_ready  out  1  block accepts a pixel this cycle
- in_sof  in  1  qualifies the first pixel of a frame
- in_pixel  in  COLORS  input pixel
- out_img  out  COLORS × [0:N_SIZE-1][0:N_SIZE-1]  window; [i][j] = row y-R+i, column x-R+j; [R][R] = center
- out_valid  out  1  window valid (no backpressure)
- out_sof  out  1  window centered on (0,0)
- out_last  out  1  window centered on (IMG_WIDTH-1, IMG_HEIGHT-1)
- out_x  out  $clog2(IMG_WIDTH)  center column
- out_y  out  $clog2(IMG_HEIGHT)  center row

## Operation
- Beat = in_valid & in_ready. Pixels arrive in raster order.
- States:
  - IDLE: in_ready=1. A beat with in_sof loads the pixel at (0,0) and goes to RUN. Beats without in_sof are dropped.
  - RUN: in_ready=1. Each beat shifts the pixel into the window and line buffers and advances the input counters.
  - RUN → FLUSH: on the beat of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - FLUSH: in_ready=0. The block shifts in one zero pixel per cycle for L = R·IMG_WIDTH + R cycles, then returns to IDLE.
- Output: the window for center index k (raster order) is emitted once input index k+L has been shifted. Flush cycles count as shifts.
- in_sof on a beat while in RUN:
  - Abort the current frame.
  - Counters restart at (0,0) with this pixel.
  - Outstanding windows of the aborted frame are never emitted.
  - out_valid stays low until the new frame reaches index L.
- Counters wrap x at IMG_WIDTH-1 → 0 with y+1. No wrap past IMG_HEIGHT-1; frame end triggers FLUSH instead.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sof=0, out_last=0, out_x=0, out_y=0, out_img all 0, state IDLE.
- in_ready rises to 1 on the first clk after reset_n deasserts.
- Outputs are registered. out_valid for center k is asserted the cycle after the beat (or flush cycle) that shifted index k+L.
- out_valid is high for exactly one cycle per center pixel: IMG_WIDTH·IMG_HEIGHT pulses per complete frame.
- Line buffer contents are not reset.
- reset_n asserted mid-frame: all state clears immediately and no further windows are emitted.

## Configuration
- NEIGHBORHOOD_BORDER_MASK_EN defined:
  - Taps outside the frame are forced to 0.
  - Affected taps: row < 0 or ≥ IMG_HEIGHT, column < 0 or ≥ IMG_WIDTH.
- Undefined:
  - Taps carry raw shift-register contents, i.e. wrapped pixels from adjacent lines or stale data.
  - This saves the compare logic; the filter threshold is then trusted to absorb edge artifacts.

## Structure
- Package neighborhood_pkg holds:
  - State enum (IDLE, RUN, FLUSH).
  - Function computing R and L from N_SIZE and IMG_WIDTH.
  - Coordinate width localparams.
- Sub-module line_buffer:
  - Single-port-per-side RAM of IMG_WIDTH×COLORS with read-before-write at the same address.
  - Instantiated N_SIZE-1 times, chained.

## Test plan
Defaults for all scenarios: N_SIZE=3, IMG_WIDTH=4, IMG_HEIGHT=3, COLORS=1, mask enabled; R=1, L=5.
- All-ones frame, in_valid held high → 12 beats then in_ready low for 5 cycles. Then 12 out_valid pulses with the following windows:
  - (0,0) has ones only at [1..2][1..2].
  - (1,1) is all ones.
  - out_last at (3,2) has ones only at [0..1][0..1].
- Single 1 at pixel (2,1), rest 0 → window [i][j]=1 exactly when the center is (2-j+1, 1-i+1). For example, center (1,0) has [2][2]=1.
- Random in_valid gaps (50%) → output sequence and values identical to the gapless run; out_valid count = 12.
- in_sof reasserted at beat 7 of frame 1 → no windows for frame 1 after that point. A full frame 2 follows with out_sof on center (0,0).
- Beats without in_sof while IDLE → dropped; no out_valid.
- reset_n pulsed low during FLUSH → all outputs 0 asynchronously; in_ready=1 one cycle after release; the next frame behaves as in the first scenario.
